// File: rtl/nic_txd_scheduler_if.sv
// Descriptor-RAM and TX-datapath signals of the NIC TX descriptor sequencer.
// master = scheduler side, slave = descriptor RAM / framer side.
interface nic_txd_scheduler_if;
  logic [7:0]  desc_addr_o;
  logic        desc_rd_o;
  logic [31:0] desc_data_i;
  logic        desc_we_o;
  logic [31:0] desc_data_o;
  logic        tx_req_o;
  logic [13:0] tx_len_o;
  logic [13:0] tx_offset_o;
  logic        tx_ack_i;
  logic        tx_done_i;
  logic        tx_error_i;

  modport master (
    output desc_addr_o, desc_rd_o, desc_we_o, desc_data_o,
    output tx_req_o, tx_len_o, tx_offset_o,
    input  desc_data_i, tx_ack_i, tx_done_i, tx_error_i
  );

  modport slave (
    input  desc_addr_o, desc_rd_o, desc_we_o, desc_data_o,
    input  tx_req_o, tx_len_o, tx_offset_o,
    output desc_data_i, tx_ack_i, tx_done_i, tx_error_i
  );
endinterface

// File: rtl/nic_txd_scheduler.sv
// TX descriptor sequencer: walks the descriptor ring, launches READY frames, writes status back.
// Optional NIC_TXD_WATCHDOG_EN adds a request/done watchdog and the tx_abort_o pulse.
module nic_txd_scheduler #(
  parameter int g_num_descs   = 8,
  parameter int g_timeout_cyc = 65535
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 kick_i,
  nic_txd_scheduler_if.master  bus,
  output logic                 irq_txdone_o,
  output logic [5:0]           cur_desc_o,
  output logic                 busy_o
`ifdef NIC_TXD_WATCHDOG_EN
  ,
  output logic                 tx_abort_o
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH0    = 3'd1;
  localparam logic [2:0] S_WAIT0     = 3'd2;
  localparam logic [2:0] S_FETCH1    = 3'd3;
  localparam logic [2:0] S_WAIT1     = 3'd4;
  localparam logic [2:0] S_ISSUE     = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;
  localparam logic [2:0] S_WB        = 3'd7;

  localparam logic [5:0]  IDX_MASK = 6'(g_num_descs - 1);
  localparam logic [13:0] MIN_LEN  = 14'd14;

  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        kick_pend_q, kick_pend_d;
  logic        en_q, en_d;
  logic [15:0] ts_id_q, ts_id_d;
  logic        err_q, err_d;
  logic [13:0] len_q, len_d;
  logic [13:0] off_q, off_d;
  logic        wd_timeout;
  logic        unused_bits;

  assign unused_bits = ^bus.desc_data_i[15:14];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ts_id_d     = ts_id_q;
    err_d       = err_q;
    len_d       = len_q;
    off_d       = off_q;
    en_d        = enable_i;
    // A kick in the same cycle as the FETCH0 read must survive: the read may predate the host write.
    kick_pend_d = kick_i | (kick_pend_q & (state_q != S_FETCH0));

    case (state_q)
      S_IDLE: begin
        if (enable_i & (kick_pend_q | kick_i | ~en_q))
          state_d = S_FETCH0;
      end
      S_FETCH0: state_d = enable_i ? S_WAIT0 : S_IDLE;
      S_WAIT0: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else begin
          ts_id_d = bus.desc_data_i[31:16];
          state_d = bus.desc_data_i[0] ? S_FETCH1 : S_IDLE;
        end
      end
      S_FETCH1: state_d = enable_i ? S_WAIT1 : S_IDLE;
      S_WAIT1: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else begin
          len_d = bus.desc_data_i[29:16];
          off_d = bus.desc_data_i[13:0];
          if (bus.desc_data_i[29:16] < MIN_LEN) begin
            err_d   = 1'b1;
            state_d = S_WB;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.tx_ack_i) begin
          state_d = S_WAIT_DONE;
        end else if (wd_timeout) begin
          err_d   = 1'b1;
          state_d = S_WB;
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_done_i) begin
          err_d   = bus.tx_error_i;
          state_d = S_WB;
        end else if (wd_timeout) begin
          err_d   = 1'b1;
          state_d = S_WB;
        end
      end
      default: begin
        idx_d   = (idx_q + 6'd1) & IDX_MASK;
        state_d = enable_i ? S_FETCH0 : S_IDLE;
      end
    endcase
  end

`ifdef NIC_TXD_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        abort_q, abort_d;
  logic        wd_active;

  assign wd_active  = (state_q == S_ISSUE) | (state_q == S_WAIT_DONE);
  assign wd_timeout = wd_active & (wd_cnt_q == 16'(g_timeout_cyc - 1));

  always_comb begin
    wd_cnt_d = 16'd0;
    if (wd_active & (state_d == state_q))
      wd_cnt_d = wd_cnt_q + 16'd1;
    abort_d = wd_timeout & (((state_q == S_ISSUE) & ~bus.tx_ack_i) |
                            ((state_q == S_WAIT_DONE) & ~bus.tx_done_i));
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      wd_cnt_q <= 16'd0;
      abort_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      abort_q  <= abort_d;
    end
  end

  assign tx_abort_o = abort_q;
`else
  assign wd_timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 6'd0;
      kick_pend_q <= 1'b0;
      en_q        <= 1'b0;
      ts_id_q     <= 16'd0;
      err_q       <= 1'b0;
      len_q       <= 14'd0;
      off_q       <= 14'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      kick_pend_q <= kick_pend_d;
      en_q        <= en_d;
      ts_id_q     <= ts_id_d;
      err_q       <= err_d;
      len_q       <= len_d;
      off_q       <= off_d;
    end
  end

  assign bus.desc_rd_o   = (state_q == S_FETCH0) | (state_q == S_FETCH1);
  assign bus.desc_addr_o = {idx_q, (state_q == S_FETCH1) ? 2'd1 : 2'd0};
  assign bus.desc_we_o   = (state_q == S_WB);
  assign bus.desc_data_o = (state_q == S_WB) ? {ts_id_q, 14'd0, err_q, 1'b0} : 32'd0;
  assign bus.tx_req_o    = (state_q == S_ISSUE);
  assign bus.tx_len_o    = len_q;
  assign bus.tx_offset_o = off_q;
  assign irq_txdone_o    = (state_q == S_WB);
  assign cur_desc_o      = idx_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_nic_txd_scheduler.sv
// Directed bench for nic_txd_scheduler: bench-side descriptor RAM, hand-driven TX datapath.
// Build with NIC_TXD_WATCHDOG_EN defined to exercise the watchdog path.
module tb_nic_txd_scheduler;
  logic        clk_sys_i = 1'b0;
  logic        rst_n_i, enable_i, kick_i;
  logic        irq_txdone_o, busy_o;
  logic [5:0]  cur_desc_o;
`ifdef NIC_TXD_WATCHDOG_EN
  logic        tx_abort_o;
`endif

  always #5 clk_sys_i = ~clk_sys_i;

  nic_txd_scheduler_if bus ();

  nic_txd_scheduler #(.g_num_descs(8), .g_timeout_cyc(100)) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .kick_i       (kick_i),
    .bus          (bus),
    .irq_txdone_o (irq_txdone_o),
    .cur_desc_o   (cur_desc_o),
    .busy_o       (busy_o)
`ifdef NIC_TXD_WATCHDOG_EN
    ,
    .tx_abort_o   (tx_abort_o)
`endif
  );

  logic [31:0] mem [0:255];
  logic        host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  int          irq_cnt = 0;

  always @(posedge clk_sys_i) begin
    if (bus.desc_rd_o) bus.desc_data_i <= mem[bus.desc_addr_o];
    if (host_we) mem[host_addr] <= host_wdata;
    else if (bus.desc_we_o) mem[bus.desc_addr_o] <= bus.desc_data_o;
    if (irq_txdone_o) irq_cnt <= irq_cnt + 1;
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic do_kick();
    kick_i = 1'b1;
    tick();
    kick_i = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!bus.tx_req_o && k < 30) begin tick(); k++; end
    check($sformatf("%s_req", tag), 32'(bus.tx_req_o), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input logic [5:0] exp_idx);
    int k = 0;
    while (busy_o && k < 30) begin tick(); k++; end
    check($sformatf("%s_busy", tag), 32'(busy_o), 32'd0);
    check($sformatf("%s_idx", tag), 32'(cur_desc_o), 32'(exp_idx));
  endtask

  task automatic serve_frame(input string tag, input logic [13:0] len, input logic [13:0] off,
                             input bit err, input bit spurious, input logic [31:0] wb);
    wait_req(tag);
    check($sformatf("%s_len", tag), 32'(bus.tx_len_o), 32'(len));
    check($sformatf("%s_off", tag), 32'(bus.tx_offset_o), 32'(off));
    if (spurious) begin
      bus.tx_done_i = 1'b1;
      tick();
      bus.tx_done_i = 1'b0;
      check($sformatf("%s_done_ignored", tag), 32'(bus.tx_req_o), 32'd1);
    end
    bus.tx_ack_i = 1'b1;
    tick();
    bus.tx_ack_i = 1'b0;
    check($sformatf("%s_req_drop", tag), 32'(bus.tx_req_o), 32'd0);
    tick();
    tick();
    bus.tx_done_i = 1'b1; bus.tx_error_i = err;
    tick();
    bus.tx_done_i = 1'b0; bus.tx_error_i = 1'b0;
    check($sformatf("%s_we", tag), 32'(bus.desc_we_o), 32'd1);
    check($sformatf("%s_irq", tag), 32'(irq_txdone_o), 32'd1);
    check($sformatf("%s_wb", tag), bus.desc_data_o, wb);
  endtask

  task automatic check_short(input string tag, input logic [7:0] addr, input logic [31:0] wb);
    int k = 0;
    bit saw = 1'b0;
    tick();
    while (!bus.desc_we_o && k < 30) begin
      if (bus.tx_req_o) saw = 1'b1;
      tick(); k++;
    end
    check($sformatf("%s_noreq", tag), 32'(saw), 32'd0);
    check($sformatf("%s_we", tag), 32'(bus.desc_we_o), 32'd1);
    check($sformatf("%s_irq", tag), 32'(irq_txdone_o), 32'd1);
    check($sformatf("%s_addr", tag), 32'(bus.desc_addr_o), 32'(addr));
    check($sformatf("%s_wb", tag), bus.desc_data_o, wb);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=no finish expected=finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int irq_base;
    rst_n_i = 1'b0; enable_i = 1'b0; kick_i = 1'b0; host_we = 1'b0;
    host_addr = 8'd0; host_wdata = 32'd0;
    bus.tx_ack_i = 1'b0; bus.tx_done_i = 1'b0; bus.tx_error_i = 1'b0;
    for (int i = 0; i < 32; i++) host_write(8'(i), 32'd0);

    // Reset state
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_idx", 32'(cur_desc_o), 32'd0);
    check("rst_req", 32'(bus.tx_req_o), 32'd0);
    check("rst_rd", 32'(bus.desc_rd_o), 32'd0);
    rst_n_i = 1'b1;
    tick();

    // Enable rise scans desc0 (empty) and stalls
    enable_i = 1'b1;
    tick(); tick();
    wait_idle("en_scan", 6'd0);

    // Single frame, with kick-to-request latency
    host_write(8'h00, 32'h1234_0001);
    host_write(8'h01, 32'h0040_0000);
    do_kick();
    tick(); tick(); tick();
    check("lat_req_early", 32'(bus.tx_req_o), 32'd0);
    tick();
    check("lat_req_5", 32'(bus.tx_req_o), 32'd1);
    check("single_len", 32'(bus.tx_len_o), 32'd64);
    check("single_off", 32'(bus.tx_offset_o), 32'd0);
    bus.tx_ack_i = 1'b1;
    tick();
    bus.tx_ack_i = 1'b0;
    check("single_req_drop", 32'(bus.tx_req_o), 32'd0);
    tick();
    check("single_busy", 32'(busy_o), 32'd1);
    bus.tx_done_i = 1'b1;
    tick();
    bus.tx_done_i = 1'b0;
    check("single_we", 32'(bus.desc_we_o), 32'd1);
    check("single_irq", 32'(irq_txdone_o), 32'd1);
    check("single_wb", bus.desc_data_o, 32'h1234_0000);
    check("single_addr", 32'(bus.desc_addr_o), 32'd0);
    tick();
    check("single_irq_pulse", 32'(irq_txdone_o), 32'd0);
    check("single_idx", 32'(cur_desc_o), 32'd1);
    wait_idle("single_stall", 6'd1);
    check("single_mem", mem[0], 32'h1234_0000);

    // Reset for 3 cycles while in ISSUE
    host_write(8'h04, 32'hAAAA_0001);
    host_write(8'h05, 32'h0020_0010);
    do_kick();
    wait_req("rstmid");
    check("rstmid_len", 32'(bus.tx_len_o), 32'd32);
    check("rstmid_off", 32'(bus.tx_offset_o), 32'h10);
    rst_n_i = 1'b0; enable_i = 1'b0;
    tick(); tick(); tick();
    check("rstmid_req", 32'(bus.tx_req_o), 32'd0);
    check("rstmid_busy", 32'(busy_o), 32'd0);
    check("rstmid_idx", 32'(cur_desc_o), 32'd0);
    check("rstmid_len0", 32'(bus.tx_len_o), 32'd0);
    check("rstmid_we", 32'(bus.desc_we_o), 32'd0);
    check("rstmid_irq", 32'(irq_txdone_o), 32'd0);
    rst_n_i = 1'b1;
    tick();

    // Full ring: 8 frames in order, wraps to desc0 which is then not ready
    for (int i = 0; i < 8; i++) begin
      host_write(8'(i * 4), {16'(16'h0100 + i), 16'h0001});
      host_write(8'(i * 4 + 1), {2'b00, 14'(64 + i), 2'b00, 14'(i * 256)});
    end
    irq_base = irq_cnt;
    enable_i = 1'b1;
    for (int i = 0; i < 8; i++)
      serve_frame($sformatf("wrap%0d", i), 14'(64 + i), 14'(i * 256), 1'b0, 1'b0,
                  {16'(16'h0100 + i), 16'h0000});
    wait_idle("wrap_end", 6'd0);
    check("wrap_irqs", 32'(irq_cnt - irq_base), 32'd8);

    // Error paths and the minimum-length boundary
    host_write(8'h00, 32'h5555_0001); host_write(8'h01, 32'h0040_0000);
    host_write(8'h04, 32'h6666_0001); host_write(8'h05, 32'h0000_0008);
    host_write(8'h08, 32'h7777_0001); host_write(8'h09, 32'h000D_0000);
    host_write(8'h0C, 32'h8888_0001); host_write(8'h0D, 32'h000E_0020);
    do_kick();
    serve_frame("txerr", 14'd64, 14'd0, 1'b1, 1'b1, 32'h5555_0002);
    check_short("len0", 8'h04, 32'h6666_0002);
    check_short("len13", 8'h08, 32'h7777_0002);
    serve_frame("len14", 14'd14, 14'h20, 1'b0, 1'b0, 32'h8888_0000);
    wait_idle("err_end", 6'd4);

    // enable_i dropped in WAIT_DONE: frame still written back, then idle; re-enable rescans
    host_write(8'h10, 32'h9999_0001); host_write(8'h11, 32'h0080_0000);
    host_write(8'h14, 32'hBBBB_0001); host_write(8'h15, 32'h0040_0040);
    do_kick();
    wait_req("endrop");
    bus.tx_ack_i = 1'b1;
    tick();
    bus.tx_ack_i = 1'b0;
    enable_i = 1'b0;
    tick(); tick();
    bus.tx_done_i = 1'b1;
    tick();
    bus.tx_done_i = 1'b0;
    check("endrop_we", 32'(bus.desc_we_o), 32'd1);
    check("endrop_wb", bus.desc_data_o, 32'h9999_0000);
    tick();
    check("endrop_idle", 32'(busy_o), 32'd0);
    check("endrop_idx", 32'(cur_desc_o), 32'd5);
    tick(); tick(); tick(); tick();
    check("endrop_stays_idle", 32'(busy_o), 32'd0);
    enable_i = 1'b1;
    serve_frame("rescan", 14'd64, 14'h40, 1'b0, 1'b0, 32'hBBBB_0000);
    wait_idle("rescan_end", 6'd6);

    // Acked frame that never reports done
    host_write(8'h18, 32'hCCCC_0001); host_write(8'h19, 32'h0040_0000);
    do_kick();
    wait_req("hang");
    bus.tx_ack_i = 1'b1;
    tick();
    bus.tx_ack_i = 1'b0;
`ifdef NIC_TXD_WATCHDOG_EN
    begin
      int n = 0;
      while (!bus.desc_we_o && n < 300) begin tick(); n++; end
      check("wd_cycles", 32'(n), 32'd100);
      check("wd_abort", 32'(tx_abort_o), 32'd1);
      check("wd_wb", bus.desc_data_o, 32'hCCCC_0002);
      tick();
      check("wd_abort_pulse", 32'(tx_abort_o), 32'd0);
    end
`else
    repeat (150) tick();
    check("hang_busy", 32'(busy_o), 32'd1);
    check("hang_no_wb", 32'(bus.desc_we_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
